// File: rtl/instr_arb_pkg.sv
// Shared constants and types for the dual-core instruction memory arbiter.
package instr_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic REQ_C0 = 1'b0;
    localparam logic REQ_C1 = 1'b1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Instruction fetch port: request/grant address phase plus in-order rvalid data phase.
interface instr_mem_arbiter_if;
    import instr_arb_pkg::*;

    logic              instr_req;
    logic [ADDR_W-1:0] instr_adr;
    logic              instr_gnt;
    logic              instr_rvalid;
    logic [DATA_W-1:0] instr_read;

    modport master (
        output instr_req,
        output instr_adr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_read
    );

    modport slave (
        input  instr_req,
        input  instr_adr,
        output instr_gnt,
        output instr_rvalid,
        output instr_read
    );

endinterface

// File: rtl/owner_fifo.sv
// 1-bit synchronous FIFO recording which core owns each outstanding memory request.
module owner_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic res_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one memory instruction port between two core caches;
// an ungranted request locks the selection, and an owner FIFO routes responses back.
module instr_mem_arbiter
    import instr_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                res_n,
    instr_mem_arbiter_if.slave  c0,
    instr_mem_arbiter_if.slave  c1,
    instr_mem_arbiter_if.master mem,
    output logic                spurious_rvalid
);

    arb_state_e state_q, state_d;
    logic       lock_id_q, lock_id_d;
    logic       prio_q, prio_d;
    logic       spurious_q, spurious_d;

    logic sel;
    logic sel_req;
    logic mem_req;
    logic grant;
    logic fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;

    // Selection and next-state; reset gating keeps memory request low while res_n is asserted.
    always_comb begin
        sel        = REQ_C0;
        sel_req    = 1'b0;
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        prio_d     = prio_q;
        spurious_d = spurious_q;

        if (state_q == ARB_LOCKED) begin
            sel     = lock_id_q;
            sel_req = (lock_id_q == REQ_C1) ? c1.instr_req : c0.instr_req;
        end else if (c0.instr_req && c1.instr_req) begin
            sel     = prio_q;
            sel_req = 1'b1;
        end else if (c1.instr_req) begin
            sel     = REQ_C1;
            sel_req = 1'b1;
        end else begin
            sel     = REQ_C0;
            sel_req = c0.instr_req;
        end

        mem_req   = res_n & sel_req & ~fifo_full;
        grant     = mem_req & mem.instr_gnt;
        fifo_push = grant;
        fifo_pop  = mem.instr_rvalid & ~fifo_empty;

        if (grant) begin
            state_d = ARB_OPEN;
            prio_d  = ~sel;
        end else if (mem_req) begin
            state_d   = ARB_LOCKED;
            lock_id_d = sel;
        end

        if (mem.instr_rvalid && fifo_empty) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ARB_OPEN;
            lock_id_q  <= REQ_C0;
            prio_q     <= REQ_C0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            prio_q     <= prio_d;
            spurious_q <= spurious_d;
        end
    end

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sel),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem.instr_req = mem_req;
    assign mem.instr_adr = !mem_req        ? '0 :
                           (sel == REQ_C1) ? c1.instr_adr : c0.instr_adr;

    assign c0.instr_gnt    = grant & (sel == REQ_C0);
    assign c1.instr_gnt    = grant & (sel == REQ_C1);
    assign c0.instr_rvalid = fifo_pop & (fifo_head == REQ_C0);
    assign c1.instr_rvalid = fifo_pop & (fifo_head == REQ_C1);
    assign c0.instr_read   = res_n ? mem.instr_read : '0;
    assign c1.instr_read   = res_n ? mem.instr_read : '0;

    assign spurious_rvalid = spurious_q;

endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Shares the single main-memory instruction port between the two cores' instruction caches (core 0 and core 1 miss ports) in the dual-core system. It uses round-robin arbitration with a request lock, so a stalled memory request is never swapped. An in-order owner FIFO tracks up to `MAX_OUTSTANDING` accepted requests, and each `rvalid` is routed back to the core that issued the request. It sits between the two `instr_cache` instances and the memory instruction interface, and adds no cycles to the grant or response path.

## Interface
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered memory requests; power of two, ≥1.
- `clk`  in  1  single clock, rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `c0_instr_req`  in  1  core-0 cache miss request; held until granted.
- `c0_instr_adr`  in  32  core-0 request address; stable while `c0_instr_req` is high.
- `c0_instr_gnt`  out  1  core-0 request accepted this cycle.
- `c0_instr_rvalid`  out  1  response for core 0 is valid this cycle.
- `c0_instr_read`  out  32  response data for core 0.
- `c1_instr_req`, `c1_instr_adr`, `c1_instr_gnt`, `c1_instr_rvalid`, `c1_instr_read`: same as core 0, for core 1.
- `instr_req`  out  1  memory request.
- `instr_adr`  out  32  memory address.
- `instr_gnt`  in  1  memory accepted the request.
- `instr_rvalid`  in  1  memory response valid; responses return in order.
- `instr_read`  in  32  memory response data.
- `spurious_rvalid`  out  1  sticky flag: `instr_rvalid` arrived while the FIFO was empty.

## Operation
- Registered state:
  - `prio`: the requester preferred on a tie; reset value 0.
  - `locked` and `lock_id`; reset values 0.
  - Owner FIFO with `MAX_OUTSTANDING` entries of 1-bit requester ID, plus a count of `$clog2(MAX_OUTSTANDING)+1` bits.
  - `spurious_rvalid`; reset value 0.
- Selection, combinational:
  - If `locked`, `sel = lock_id`.
  - Otherwise, if exactly one requester is asserting `req`, `sel` is that requester.
  - Otherwise, if both are asserting, `sel = prio`.
- Memory request:
  - `instr_req = sel_req & ~fifo_full`.
  - `instr_adr` = the selected requester's address when `instr_req` is high, else 0.
- Grant:
  - `cX_instr_gnt = instr_req & instr_gnt & (sel==X)`.
  - On a grant: push `sel` into the FIFO, set `prio = ~sel`, clear `locked`.
- Lock: if `instr_req & ~instr_gnt`, set `locked` and `lock_id = sel`. The selection cannot change while memory sees a pending request.
- Response:
  - `cX_instr_rvalid = instr_rvalid & ~fifo_empty & (head==X)`; pop the FIFO on `instr_rvalid & ~fifo_empty`.
  - `instr_read` drives both `cX_instr_read` unconditionally. Consumers qualify it with `rvalid`.
- Simultaneous push and pop in one cycle: the count is unchanged and is legal even when the FIFO is full. A pop frees no slot for the same-cycle `instr_req`, so `fifo_full` uses the registered count.
- `instr_rvalid` while the FIFO is empty: no `rvalid` to either core, no pop, set `spurious_rvalid`. It stays set until reset.
- Full FIFO: `instr_req` is low and no grants are issued. `locked` is unchanged.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`.
- Reset asserted mid-transaction: the FIFO empties, `locked` clears, `prio` = 0, and all outputs go to 0 at once (asynchronously). Memory responses still in flight after reset count as spurious.

## Timing
- Grant and response pass through in zero cycles. Requester-to-memory adds no latency.
- A new arbitration decision is possible every cycle, so back-to-back grants are allowed (alternating under contention).
- The lock takes effect from the cycle after an ungranted `instr_req`.

## Structure
- Package `instr_arb_pkg` holds:
  - requester ID constants `REQ_C0 = 1'b0`, `REQ_C1 = 1'b1`;
  - `ADDR_W = 32` and `DATA_W = 32`.
- Sub-module `owner_fifo`: synchronous FIFO of width 1, depth `MAX_OUTSTANDING`, async active-low reset. Ports: push, pop, `din`, `dout`, full, empty.

## Test plan
- Core 0 alone requests 0x100; memory grants in the same cycle and sends `rvalid` 3 cycles later with 0xDEADBEEF → `c0_instr_gnt` pulses once; `c0_instr_rvalid=1` with `c0_instr_read=0xDEADBEEF`; `c1_instr_rvalid` stays 0.
- Both cores request 0x200 and 0x300 after reset, and memory always grants → core 0 is granted first, then core 1. `instr_adr` shows 0x200 then 0x300; responses route to c0 then c1.
- Core 1 requests 0x40 and memory withholds `instr_gnt` for 4 cycles while core 0 starts requesting at cycle 2 → `instr_adr` stays 0x40 until granted, and core 0 is granted on the next cycle.
- `MAX_OUTSTANDING=2`: two grants with no responses → `instr_req`=0 despite a pending request. A single `rvalid` re-enables the request on the following cycle.
- Full FIFO with `instr_rvalid` and a new request in the same cycle → pop happens, no push that cycle, count goes to 1.
- `instr_rvalid` with nothing outstanding → no core `rvalid`, and `spurious_rvalid`=1 until `res_n` is low. Asserting `res_n` low mid-transaction clears all outputs asynchronously.
